// File: rtl/spi_master_fifo.sv
// spi_master_fifo: SPI master with a command FIFO, runtime CPOL/CPHA and SCK divider.
// Commands {slave select, data} are queued from the control side. Each command is then
// shifted full-duplex, MSB first, and the received word is returned with a one-cycle Ready_o.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | selects high, SCK follows Cpol_i, pops the next command if one is queued
// SETUP | selected slave asserted for H cycles before the first SCK edge
// XFER  | 2*DATA_W SCK toggles, one every H cycles
// HOLD  | SCK back at CPOL, select held for H cycles; result published on exit
// GAP   | selects deasserted for H cycles before the next word
module spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int NUM_SS     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CLKDIV_W   = 8
) (
  input  logic                Clk_i,
  input  logic                Rst_i,
  input  logic [DATA_W-1:0]   ToXmit_i,
  input  logic [NUM_SS-1:0]   Ss_i,
  input  logic                Strobe_i,
  input  logic                Cpol_i,
  input  logic                Cpha_i,
  input  logic [CLKDIV_W-1:0] ClkDiv_i,
  output logic [DATA_W-1:0]   Rcvd_o,
  output logic                Ready_o,
  output logic                XmitFull_o,
  output logic                Busy_o,
  output logic                Err_o,
  input  logic                Miso_i,
  output logic                Mosi_o,
  output logic                Sck_o,
  output logic [NUM_SS-1:0]   SsN_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TOG_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_GAP
  } state_t;

  state_t state;

  logic                strobe_q;
  logic                push_edge;
  logic                ss_onehot;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push_ok;
  logic                pop;

  logic [NUM_SS-1:0]   fifo_ss   [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic [CLKDIV_W-1:0] tmr;
  logic [CLKDIV_W-1:0] div_q;
  logic [TOG_W-1:0]    tog_left;
  logic                cpol_q;
  logic                cpha_q;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;

  // Toggle parity: with an even total, the toggle about to happen is odd (leading)
  // exactly when the remaining count is even.
  logic                tog_odd;
  logic                tog_sample;

  assign push_edge  = Strobe_i & ~strobe_q;
  assign ss_onehot  = (Ss_i != '0) && ((Ss_i & (Ss_i - NUM_SS'(1))) == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is dropped.
  assign push_ok    = push_edge & ss_onehot & ~fifo_full;
  assign pop        = (state == S_IDLE) & ~fifo_empty;

  assign tog_odd    = ~tog_left[0];
  assign tog_sample = cpha_q ? ~tog_odd : tog_odd;

  assign XmitFull_o = fifo_full;
  assign Busy_o     = (state != S_IDLE) | ~fifo_empty;

  // Strobe edge detector
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) strobe_q <= 1'b0;
    else       strobe_q <= Strobe_i;
  end

  // Sticky error: dropped command (overflow or invalid select)
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i)                                    Err_o <= 1'b0;
    else if (push_edge & (~ss_onehot | fifo_full)) Err_o <= 1'b1;
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge Clk_i) begin
    if (push_ok) begin
      fifo_ss[wr_ptr]   <= Ss_i;
      fifo_data[wr_ptr] <= ToXmit_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transfer sequencer with registered bus outputs
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state    <= S_IDLE;
      tmr      <= '0;
      div_q    <= '0;
      tog_left <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      Rcvd_o   <= '0;
      Ready_o  <= 1'b0;
      Mosi_o   <= 1'b0;
      Sck_o    <= 1'b0;
      SsN_o    <= '1;
    end else begin
      Ready_o <= 1'b0;
      case (state)
        S_IDLE: begin
          Sck_o <= Cpol_i;
          SsN_o <= '1;
          if (pop) begin
            cpol_q <= Cpol_i;
            cpha_q <= Cpha_i;
            div_q  <= ClkDiv_i;
            tmr    <= ClkDiv_i;
            tx_sr  <= fifo_data[rd_ptr];
            rx_sr  <= '0;
            SsN_o  <= ~fifo_ss[rd_ptr];
            // Mode 0/2 slaves sample on the leading edge, so the MSB goes out during SETUP.
            if (!Cpha_i) Mosi_o <= fifo_data[rd_ptr][DATA_W-1];
            state  <= S_SETUP;
          end
        end

        S_SETUP: begin
          Sck_o <= cpol_q;
          if (tmr == '0) begin
            tmr      <= div_q;
            tog_left <= TOG_W'(2 * DATA_W);
            state    <= S_XFER;
          end else begin
            tmr <= tmr - CLKDIV_W'(1);
          end
        end

        S_XFER: begin
          if (tmr == '0) begin
            tmr      <= div_q;
            Sck_o    <= ~Sck_o;
            tog_left <= tog_left - TOG_W'(1);
            if (tog_sample) begin
              rx_sr <= {rx_sr[DATA_W-2:0], Miso_i};
            end else if (cpha_q) begin
              Mosi_o <= tx_sr[DATA_W-1];
              tx_sr  <= tx_sr << 1;
            end else if (tog_left != TOG_W'(1)) begin
              Mosi_o <= tx_sr[DATA_W-2];
              tx_sr  <= tx_sr << 1;
            end
            if (tog_left == TOG_W'(1)) state <= S_HOLD;
          end else begin
            tmr <= tmr - CLKDIV_W'(1);
          end
        end

        S_HOLD: begin
          if (tmr == '0) begin
            tmr     <= div_q;
            SsN_o   <= '1;
            Rcvd_o  <= rx_sr;
            Ready_o <= 1'b1;
            state   <= S_GAP;
          end else begin
            tmr <= tmr - CLKDIV_W'(1);
          end
        end

        S_GAP: begin
          Sck_o <= cpol_q;
          if (tmr == '0) state <= S_IDLE;
          else           tmr   <= tmr - CLKDIV_W'(1);
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: directed sequence with randomized words/modes/dividers, checked
// against a behavioural SPI slave and a queue model of accepted commands.
module tb_spi_master_fifo;

  logic tbClks = 1'b0;
  always #5 tbClks = ~tbClks;

  logic rst;

  // Instance A: default parameters
  logic [7:0]  a_tx;
  logic [1:0]  a_ss;
  logic        a_strobe, a_cpol, a_cpha;
  logic [7:0]  a_div;
  logic [7:0]  a_rcvd;
  logic        a_ready, a_full, a_busy, a_err;
  logic        a_miso, a_mosi, a_sck;
  logic [1:0]  a_ssn;

  // Instance B: 16-bit word, four selects
  logic [15:0] b_tx;
  logic [3:0]  b_ss;
  logic        b_strobe;
  logic [7:0]  b_div;
  logic [15:0] b_rcvd;
  logic        b_ready, b_full, b_busy, b_err;
  logic        b_miso, b_mosi, b_sck;
  logic [3:0]  b_ssn;

  spi_master_fifo dut_a (
    .Clk_i(tbClks), .Rst_i(rst), .ToXmit_i(a_tx), .Ss_i(a_ss), .Strobe_i(a_strobe),
    .Cpol_i(a_cpol), .Cpha_i(a_cpha), .ClkDiv_i(a_div), .Rcvd_o(a_rcvd), .Ready_o(a_ready),
    .XmitFull_o(a_full), .Busy_o(a_busy), .Err_o(a_err), .Miso_i(a_miso), .Mosi_o(a_mosi),
    .Sck_o(a_sck), .SsN_o(a_ssn)
  );

  spi_master_fifo #(.DATA_W(16), .NUM_SS(4), .FIFO_DEPTH(4), .CLKDIV_W(8)) dut_b (
    .Clk_i(tbClks), .Rst_i(rst), .ToXmit_i(b_tx), .Ss_i(b_ss), .Strobe_i(b_strobe),
    .Cpol_i(1'b0), .Cpha_i(1'b0), .ClkDiv_i(b_div), .Rcvd_o(b_rcvd), .Ready_o(b_ready),
    .XmitFull_o(b_full), .Busy_o(b_busy), .Err_o(b_err), .Miso_i(b_miso), .Mosi_o(b_mosi),
    .Sck_o(b_sck), .SsN_o(b_ssn)
  );

  // Slave model for A, or a straight loopback
  logic        loop_a;
  logic [7:0]  sl_ret, sl_rx;
  logic        sl_miso;
  int          sl_idx;
  assign a_miso = loop_a ? a_mosi : sl_miso;
  assign b_miso = b_mosi;

  // Bus monitors
  logic        a_sck_q, b_sck_q;
  logic [1:0]  a_ssn_q;
  int          a_tog, a_rise, a_ss0_low, a_multi, a_ready_cnt;
  bit          a_full_seen, a_busy_seen;
  logic [7:0]  a_rx_q[$];
  logic [7:0]  exp_q[$];
  int          b_tog, b_ss3_low, b_bad, b_ready_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sampling on the falling edge and running monitors and slave.
  task automatic step();
    logic lead;
    @(negedge tbClks);
    if (a_ready) begin a_ready_cnt++; a_rx_q.push_back(a_rcvd); end
    if (a_full) a_full_seen = 1'b1;
    if (a_busy) a_busy_seen = 1'b1;
    if (a_ssn == 2'b10) a_ss0_low++;
    if (a_ssn == 2'b00) a_multi++;
    if (a_ssn != 2'b11 && a_ssn_q == 2'b11) begin
      sl_idx = 0;
      sl_rx  = '0;
      if (!a_cpha) begin sl_miso = sl_ret[7]; sl_idx = 1; end
    end
    if (a_sck !== a_sck_q) begin
      a_tog++;
      if (a_sck) a_rise++;
      if (a_ssn != 2'b11) begin
        lead = (a_sck != a_cpol);
        if (lead == !a_cpha) sl_rx = {sl_rx[6:0], a_mosi};
        else if (sl_idx < 8) begin sl_miso = sl_ret[7 - sl_idx]; sl_idx++; end
      end
    end
    a_sck_q = a_sck;
    a_ssn_q = a_ssn;
    if (b_ready) b_ready_cnt++;
    if (b_sck !== b_sck_q) b_tog++;
    b_sck_q = b_sck;
    if (b_ssn == 4'b0111) b_ss3_low++;
    else if (b_ssn != 4'b1111) b_bad++;
  endtask

  task automatic push_a(input logic [1:0] ss, input logic [7:0] d);
    a_ss = ss; a_tx = d; a_strobe = 1'b1;
    step();
    a_strobe = 1'b0;
    step();
  endtask

  task automatic wait_a_ready(input int target, input int budget, input string tag);
    int n = 0;
    while (a_ready_cnt < target && n < budget) begin step(); n++; end
    check(tag, 32'(a_ready_cnt >= target), 32'(1));
  endtask

  task automatic wait_a_idle(input int budget, input string tag);
    int n = 0;
    while (a_busy && n < budget) begin step(); n++; end
    check(tag, 32'(a_busy), 32'(0));
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int t0, r0, s0, rc0, n, m, dv, queued;
    logic [7:0] w;
    bit started, err_exp;

    rst = 1'b1;
    a_tx = '0; a_ss = '0; a_strobe = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0; a_div = 8'd1;
    b_tx = '0; b_ss = '0; b_strobe = 1'b0; b_div = 8'd0;
    loop_a = 1'b1; sl_ret = '0; sl_rx = '0; sl_miso = 1'b0; sl_idx = 0;
    a_sck_q = 1'b0; b_sck_q = 1'b0; a_ssn_q = 2'b11;
    a_tog = 0; a_rise = 0; a_ss0_low = 0; a_multi = 0; a_ready_cnt = 0;
    b_tog = 0; b_ss3_low = 0; b_bad = 0; b_ready_cnt = 0;
    a_full_seen = 1'b0; a_busy_seen = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_rcvd",  32'(a_rcvd),  32'(0));
    check("rst_ready", 32'(a_ready), 32'(0));
    check("rst_full",  32'(a_full),  32'(0));
    check("rst_busy",  32'(a_busy),  32'(0));
    check("rst_err",   32'(a_err),   32'(0));
    check("rst_mosi",  32'(a_mosi),  32'(0));
    check("rst_sck",   32'(a_sck),   32'(0));
    check("rst_ssn",   32'(a_ssn),   32'(2'b11));
    rst = 1'b0;
    repeat (2) step();

    // Mode 0, H=2, loopback 0xA5
    t0 = a_tog; r0 = a_rise; s0 = a_ss0_low; rc0 = a_ready_cnt;
    a_ss = 2'b01; a_tx = 8'hA5; a_strobe = 1'b1;
    step();
    check("lat_not_yet", 32'(a_ssn), 32'(2'b11));
    a_strobe = 1'b0;
    step();
    check("lat_ss_low", 32'(a_ssn), 32'(2'b10));
    wait_a_ready(rc0 + 1, 200, "m0_ready_timeout");
    wait_a_idle(100, "m0_idle_timeout");
    check("m0_rcvd",     32'(a_rcvd), 32'(8'hA5));
    check("m0_pulses",   32'(a_ready_cnt - rc0), 32'(1));
    check("m0_ss_low",   32'(a_ss0_low - s0), 32'(36));
    check("m0_rises",    32'(a_rise - r0), 32'(8));
    check("m0_toggles",  32'(a_tog - t0), 32'(16));
    a_rx_q.delete();

    // Modes 1..3 against the slave model
    loop_a = 1'b0;
    sl_ret = 8'h3C;
    for (int md = 1; md < 4; md++) begin
      a_cpol = md[1]; a_cpha = md[0];
      repeat (4) step();
      rc0 = a_ready_cnt;
      push_a(2'b01, 8'hC3);
      wait_a_ready(rc0 + 1, 200, "mode_ready_timeout");
      wait_a_idle(100, "mode_idle_timeout");
      check("mode_rcvd",    32'(a_rcvd), 32'(8'h3C));
      check("mode_slv_rx",  32'(sl_rx),  32'(8'hC3));
      check("mode_sck_idle", 32'(a_sck), 32'(md[1]));
    end
    a_rx_q.delete();

    // Random words, modes and dividers in loopback
    loop_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m  = int'($urandom_range(0, 3));
      dv = int'($urandom_range(0, 3));
      w  = 8'($urandom);
      a_cpol = m[1]; a_cpha = m[0]; a_div = 8'(dv);
      repeat (3) step();
      t0 = a_tog; s0 = a_ss0_low; rc0 = a_ready_cnt;
      push_a(2'b01, w);
      wait_a_ready(rc0 + 1, 400, "rnd_ready_timeout");
      wait_a_idle(100, "rnd_idle_timeout");
      check("rnd_rcvd",    32'(a_rcvd), 32'(w));
      check("rnd_ss_low",  32'(a_ss0_low - s0), 32'(18 * (dv + 1)));
      check("rnd_toggles", 32'(a_tog - t0), 32'(16));
    end
    a_rx_q.delete();

    // Six back-to-back commands into a depth-4 FIFO during a long transfer
    a_cpol = 1'b0; a_cpha = 1'b0; a_div = 8'd7;
    repeat (3) step();
    a_full_seen = 1'b0;
    exp_q.delete();
    started = 1'b0; queued = 0; err_exp = 1'b0;
    rc0 = a_ready_cnt;
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom);
      if (!started) begin started = 1'b1; exp_q.push_back(w); end
      else if (queued < 4) begin queued++; exp_q.push_back(w); end
      else err_exp = 1'b1;
      push_a(2'b01, w);
      check("ovf_full", 32'(a_full), 32'(queued == 4));
    end
    check("ovf_err", 32'(a_err), 32'(err_exp));
    wait_a_ready(rc0 + 5, 2000, "ovf_ready_timeout");
    wait_a_idle(200, "ovf_idle_timeout");
    check("ovf_count", 32'(a_rx_q.size()), 32'(exp_q.size()));
    while (a_rx_q.size() > 0 && exp_q.size() > 0)
      check("ovf_order", 32'(a_rx_q.pop_front()), 32'(exp_q.pop_front()));
    check("ovf_full_seen", 32'(a_full_seen), 32'(1));
    check("ovf_full_end",  32'(a_full), 32'(0));
    a_rx_q.delete();

    // Invalid selects are dropped
    a_div = 8'd1;
    for (int j = 0; j < 2; j++) begin
      do_reset();
      check("inv_err_clr", 32'(a_err), 32'(0));
      t0 = a_tog;
      a_busy_seen = 1'b0;
      push_a((j == 0) ? 2'b00 : 2'b11, 8'h55);
      repeat (10) step();
      check("inv_err",  32'(a_err), 32'(1));
      check("inv_busy", 32'(a_busy_seen), 32'(0));
      check("inv_sck",  32'(a_tog - t0), 32'(0));
    end

    // Reset in the middle of a word
    do_reset();
    t0 = a_tog; rc0 = a_ready_cnt;
    push_a(2'b01, 8'h5A);
    n = 0;
    while ((a_tog - t0) < 5 && n < 200) begin step(); n++; end
    check("mid_reached", 32'(a_tog - t0 >= 5), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_ssn",  32'(a_ssn),  32'(2'b11));
    check("mid_sck",  32'(a_sck),  32'(0));
    check("mid_busy", 32'(a_busy), 32'(0));
    step();
    rst = 1'b0;
    repeat (30) step();
    check("mid_no_ready", 32'(a_ready_cnt - rc0), 32'(0));
    a_rx_q.delete();
    push_a(2'b01, 8'h5A);
    wait_a_ready(rc0 + 1, 200, "mid_ready_timeout");
    wait_a_idle(100, "mid_idle_timeout");
    check("mid_rcvd", 32'(a_rcvd), 32'(8'h5A));

    // 16-bit instance, fastest divider, top select
    t0 = b_tog; s0 = b_ss3_low; rc0 = b_ready_cnt;
    b_ss = 4'b1000; b_tx = 16'hBEEF; b_strobe = 1'b1;
    step();
    b_strobe = 1'b0;
    n = 0;
    while (b_ready_cnt == rc0 && n < 300) begin step(); n++; end
    check("b_ready_timeout", 32'(b_ready_cnt - rc0), 32'(1));
    repeat (5) step();
    check("b_rcvd",    32'(b_rcvd), 32'(16'hBEEF));
    check("b_toggles", 32'(b_tog - t0), 32'(32));
    check("b_ss3_low", 32'(b_ss3_low - s0), 32'(34));
    check("b_bad_ss",  32'(b_bad), 32'(0));
    check("b_err",     32'(b_err), 32'(0));
    check("b_full",    32'(b_full), 32'(0));
    check("b_busy",    32'(b_busy), 32'(0));

    check("a_multi_ss", 32'(a_multi), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
